// File: rtl/pc_fetch_unit_pkg.sv
// Shared core package.
// Contents:
//   - pc_state_e: fetch sequencer states.
//   - XLEN_DEFAULT: default datapath width.
//   - RESET_VECTOR_DEFAULT: default reset PC.
package rv_core_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        HOLD  = 2'd2,
        KILL  = 2'd3
    } pc_state_e;

    localparam int          XLEN_DEFAULT         = 32;
    localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Instruction-memory fetch handshake (req/ack).
// Signals:
//   - fetch_req: request valid; driven by the fetch unit.
//   - fetch_addr: request address; driven by the fetch unit.
//   - fetch_ack: memory accepted the request; data returned this cycle.
//   - fetch_rdata: instruction word, valid with fetch_ack.
// Modports:
//   - master: the fetch unit.
//   - slave: the memory.
interface pc_fetch_unit_if #(
    parameter int XLEN = rv_core_pkg::XLEN_DEFAULT
);
    logic            fetch_req;
    logic [XLEN-1:0] fetch_addr;
    logic            fetch_ack;
    logic [31:0]     fetch_rdata;

    modport master (output fetch_req, fetch_addr, input fetch_ack, fetch_rdata);
    modport slave  (input fetch_req, fetch_addr, output fetch_ack, fetch_rdata);
endinterface

// File: rtl/pc_fetch_unit_redirect_sel.sv
// Combinational redirect selection. The module is named pc_redirect_sel.
// Function:
//   - Trap has priority over branch.
//   - The trap target is forced onto the alignment grid.
//   - A misaligned branch is dropped and flagged.
// Ports:
//   - branch_i, branch_target_i: branch request.
//   - trap_i, trap_target_i: trap request.
//   - redirect_o: the PC must be reloaded.
//   - target_o: the new PC.
//   - misalign_o: a branch was dropped for misalignment, with no trap present.
module pc_redirect_sel #(
    parameter int XLEN = rv_core_pkg::XLEN_DEFAULT,
    parameter int STEP = 4
) (
    input  logic            branch_i,
    input  logic [XLEN-1:0] branch_target_i,
    input  logic            trap_i,
    input  logic [XLEN-1:0] trap_target_i,
    output logic            redirect_o,
    output logic [XLEN-1:0] target_o,
    output logic            misalign_o
);
    localparam logic [XLEN-1:0] MASK = XLEN'(STEP - 1);

    logic aligned;

    assign aligned    = (branch_target_i & MASK) == '0;
    assign redirect_o = trap_i | (branch_i & aligned);
    assign target_o   = trap_i ? (trap_target_i & ~MASK) : branch_target_i;
    assign misalign_o = branch_i & ~aligned & ~trap_i;
endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter and fetch sequencer for the IF stage.
// Function:
//   - Issues req/ack fetches to instruction memory.
//   - Applies stalls and trap/branch redirects.
//   - Drops responses made stale by a redirect.
// Ports:
//   - clk, rst_n: clock; asynchronous active-low reset.
//   - mem: fetch handshake, master side.
//   - stall_i: the downstream stage cannot accept.
//   - branch_i, branch_target_i: branch redirect request.
//   - trap_i, trap_target_i: trap redirect request.
//   - pc_o: next PC to be fetched.
//   - inst_valid_o, inst_o, inst_pc_o: delivered instruction (one-cycle pulse).
//   - misalign_o: one-cycle pulse when a branch was dropped.
//
// state | meaning
// IDLE  | first cycle after reset release, no request
// ISSUE | request for pc_o outstanding
// HOLD  | stalled, no request
// KILL  | stale request outstanding, its response will be dropped
module pc_fetch_unit
    import rv_core_pkg::*;
#(
    parameter int              XLEN         = XLEN_DEFAULT,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(RESET_VECTOR_DEFAULT),
    parameter int              STEP         = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    pc_fetch_unit_if.master   mem,
    input  logic              stall_i,
    input  logic              branch_i,
    input  logic [XLEN-1:0]   branch_target_i,
    input  logic              trap_i,
    input  logic [XLEN-1:0]   trap_target_i,
    output logic [XLEN-1:0]   pc_o,
    output logic              inst_valid_o,
    output logic [31:0]       inst_o,
    output logic [XLEN-1:0]   inst_pc_o,
    output logic              misalign_o
);
    pc_state_e       state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic            req_q, req_d;
    logic [31:0]     inst_q, inst_d;
    logic [XLEN-1:0] inst_pc_q, inst_pc_d;
    logic            valid_q, valid_d;
    logic            misalign_q, misalign_d;

    logic            redirect;
    logic [XLEN-1:0] target;
    logic            sel_misalign;

    pc_redirect_sel #(.XLEN(XLEN), .STEP(STEP)) u_redirect_sel (
        .branch_i        (branch_i),
        .branch_target_i (branch_target_i),
        .trap_i          (trap_i),
        .trap_target_i   (trap_target_i),
        .redirect_o      (redirect),
        .target_o        (target),
        .misalign_o      (sel_misalign)
    );

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        addr_d     = addr_q;
        inst_d     = inst_q;
        inst_pc_d  = inst_pc_q;
        valid_d    = 1'b0;
        misalign_d = sel_misalign;

        case (state_q)
            IDLE: begin
                if (redirect) pc_d = target;
                state_d = stall_i ? HOLD : ISSUE;
            end
            ISSUE: begin
                if (mem.fetch_ack) begin
                    if (redirect) begin
                        pc_d = target;
                    end else begin
                        valid_d   = 1'b1;
                        inst_d    = mem.fetch_rdata;
                        inst_pc_d = addr_q;
                        pc_d      = pc_q + XLEN'(STEP);
                    end
                    state_d = stall_i ? HOLD : ISSUE;
                end else if (redirect) begin
                    pc_d    = target;
                    state_d = KILL;
                end
            end
            HOLD: begin
                if (redirect) pc_d = target;
                if (!stall_i) state_d = ISSUE;
            end
            KILL: begin
                if (redirect) pc_d = target;
                if (mem.fetch_ack) state_d = stall_i ? HOLD : ISSUE;
            end
            default: state_d = IDLE;
        endcase

        // In ISSUE the address always tracks the PC; this covers both ISSUE
        // entry and a plain wait, where pc_d equals the held address.
        if (state_d == ISSUE) addr_d = pc_d;
        req_d = (state_d == ISSUE) || (state_d == KILL);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pc_q       <= RESET_VECTOR;
            addr_q     <= RESET_VECTOR;
            req_q      <= 1'b0;
            inst_q     <= '0;
            inst_pc_q  <= '0;
            valid_q    <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            addr_q     <= addr_d;
            req_q      <= req_d;
            inst_q     <= inst_d;
            inst_pc_q  <= inst_pc_d;
            valid_q    <= valid_d;
            misalign_q <= misalign_d;
        end
    end

    assign mem.fetch_req  = req_q;
    assign mem.fetch_addr = addr_q;
    assign pc_o           = pc_q;
    assign inst_valid_o   = valid_q;
    assign inst_o         = inst_q;
    assign inst_pc_o      = inst_pc_q;
    assign misalign_o     = misalign_q;
endmodule

// File: tb/tb_pc_fetch_unit.sv
module tb_pc_fetch_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rstb_n = 1'b0;
    logic        stall = 1'b0;
    logic        branch = 1'b0;
    logic [31:0] btgt = '0;
    logic        trap = 1'b0;
    logic [31:0] ttgt = '0;

    logic [31:0] pc_a, inst_a, ipc_a, pc_b, inst_b, ipc_b;
    logic        val_a, mis_a, val_b, mis_b;

    int errors = 0;
    int checks = 0;

    pc_fetch_unit_if #(.XLEN(32)) ifa ();
    pc_fetch_unit_if #(.XLEN(32)) ifb ();

    pc_fetch_unit u_dut (
        .clk(clk), .rst_n(rst_n), .mem(ifa.master),
        .stall_i(stall), .branch_i(branch), .branch_target_i(btgt),
        .trap_i(trap), .trap_target_i(ttgt),
        .pc_o(pc_a), .inst_valid_o(val_a), .inst_o(inst_a),
        .inst_pc_o(ipc_a), .misalign_o(mis_a)
    );

    pc_fetch_unit #(.RESET_VECTOR(32'hFFFF_FFFC)) u_dut_wrap (
        .clk(clk), .rst_n(rstb_n), .mem(ifb.master),
        .stall_i(stall), .branch_i(branch), .branch_target_i(btgt),
        .trap_i(trap), .trap_target_i(ttgt),
        .pc_o(pc_b), .inst_valid_o(val_b), .inst_o(inst_b),
        .inst_pc_o(ipc_b), .misalign_o(mis_b)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        ifa.fetch_ack = 1'b0; ifa.fetch_rdata = '0;
        ifb.fetch_ack = 1'b0; ifb.fetch_rdata = '0;
        #3;
        checks++; if (pc_a !== 32'h0) begin errors++; $display("FAIL reset_pc got %h exp %h", pc_a, 32'h0); end
        checks++; if (ifa.fetch_addr !== 32'h0) begin errors++; $display("FAIL reset_addr got %h exp %h", ifa.fetch_addr, 32'h0); end
        checks++; if (ifa.fetch_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b exp 0", ifa.fetch_req); end
        checks++; if ({val_a, mis_a} !== 2'b00) begin errors++; $display("FAIL reset_pulses got %b exp 00", {val_a, mis_a}); end
        checks++; if ({inst_a, ipc_a} !== 64'h0) begin errors++; $display("FAIL reset_inst got %h exp 0", {inst_a, ipc_a}); end
        rst_n = 1'b1;
        step();
        checks++; if ({ifa.fetch_req, ifa.fetch_addr} !== {1'b1, 32'h0}) begin errors++; $display("FAIL first_req got %b/%h exp 1/0", ifa.fetch_req, ifa.fetch_addr); end
    endtask

    task automatic test_sequential();
        logic [31:0] a;
        for (int i = 0; i < 2; i++) begin
            a = 32'(4 * i);
            ifa.fetch_ack = 1'b1; ifa.fetch_rdata = a ^ 32'hA5A5_0000;
            step();
            checks++; if ({val_a, inst_a, ipc_a} !== {1'b1, a ^ 32'hA5A5_0000, a})
                begin errors++; $display("FAIL seq_inst[%0d] got %b/%h/%h exp 1/%h/%h", i, val_a, inst_a, ipc_a, a ^ 32'hA5A5_0000, a); end
            checks++; if ({ifa.fetch_req, ifa.fetch_addr, pc_a} !== {1'b1, a + 32'd4, a + 32'd4})
                begin errors++; $display("FAIL seq_addr[%0d] got %b/%h/%h exp 1/%h", i, ifa.fetch_req, ifa.fetch_addr, pc_a, a + 32'd4); end
        end
        ifa.fetch_ack = 1'b0;
        step();
        checks++; if ({val_a, ifa.fetch_req, ifa.fetch_addr} !== {1'b0, 1'b1, 32'h8})
            begin errors++; $display("FAIL seq_wait got %b/%b/%h exp 0/1/8", val_a, ifa.fetch_req, ifa.fetch_addr); end
    endtask

    task automatic test_redirect_delayed_ack();
        branch = 1'b1; btgt = 32'h100;
        step();
        branch = 1'b0;
        checks++; if ({pc_a, ifa.fetch_addr, ifa.fetch_req} !== {32'h100, 32'h8, 1'b1})
            begin errors++; $display("FAIL kill_hold got %h/%h/%b exp 100/8/1", pc_a, ifa.fetch_addr, ifa.fetch_req); end
        step();
        step();
        ifa.fetch_ack = 1'b1; ifa.fetch_rdata = 32'hDEAD_BEEF;
        step();
        ifa.fetch_ack = 1'b0;
        checks++; if (val_a !== 1'b0) begin errors++; $display("FAIL stale_valid got %b exp 0", val_a); end
        checks++; if ({ifa.fetch_req, ifa.fetch_addr} !== {1'b1, 32'h100})
            begin errors++; $display("FAIL redirect_addr got %b/%h exp 1/100", ifa.fetch_req, ifa.fetch_addr); end
    endtask

    task automatic test_trap_misaligned();
        trap = 1'b1; ttgt = 32'h203; branch = 1'b1; btgt = 32'h41;
        step();
        trap = 1'b0; branch = 1'b0;
        checks++; if (pc_a !== 32'h200) begin errors++; $display("FAIL trap_pc got %h exp 200", pc_a); end
        checks++; if (mis_a !== 1'b0) begin errors++; $display("FAIL trap_masks_misalign got %b exp 0", mis_a); end
        ifa.fetch_ack = 1'b1; ifa.fetch_rdata = 32'h1111_1111;
        step();
        ifa.fetch_ack = 1'b0;
        checks++; if ({val_a, ifa.fetch_addr} !== {1'b0, 32'h200})
            begin errors++; $display("FAIL trap_refetch got %b/%h exp 0/200", val_a, ifa.fetch_addr); end
        branch = 1'b1; btgt = 32'h41;
        ifa.fetch_ack = 1'b1; ifa.fetch_rdata = 32'h2222_2222;
        step();
        branch = 1'b0; ifa.fetch_ack = 1'b0;
        checks++; if (mis_a !== 1'b1) begin errors++; $display("FAIL misalign_pulse got %b exp 1", mis_a); end
        checks++; if ({val_a, inst_a, ipc_a, pc_a} !== {1'b1, 32'h2222_2222, 32'h200, 32'h204})
            begin errors++; $display("FAIL misalign_advance got %b/%h/%h/%h exp 1/22222222/200/204", val_a, inst_a, ipc_a, pc_a); end
        step();
        checks++; if ({mis_a, val_a} !== 2'b00) begin errors++; $display("FAIL misalign_one_cycle got %b exp 00", {mis_a, val_a}); end
    endtask

    task automatic test_stall();
        stall = 1'b1;
        step();
        checks++; if ({ifa.fetch_req, ifa.fetch_addr} !== {1'b1, 32'h204})
            begin errors++; $display("FAIL stall_outstanding got %b/%h exp 1/204", ifa.fetch_req, ifa.fetch_addr); end
        ifa.fetch_ack = 1'b1; ifa.fetch_rdata = 32'h3333_3333;
        step();
        ifa.fetch_ack = 1'b0;
        checks++; if ({val_a, inst_a, ipc_a, ifa.fetch_req} !== {1'b1, 32'h3333_3333, 32'h204, 1'b0})
            begin errors++; $display("FAIL stall_complete got %b/%h/%h/%b exp 1/33333333/204/0", val_a, inst_a, ipc_a, ifa.fetch_req); end
        step();
        step();
        checks++; if ({ifa.fetch_req, val_a} !== 2'b00) begin errors++; $display("FAIL stall_hold got %b exp 00", {ifa.fetch_req, val_a}); end
        stall = 1'b0;
        step();
        checks++; if ({ifa.fetch_req, ifa.fetch_addr} !== {1'b1, 32'h208})
            begin errors++; $display("FAIL stall_resume got %b/%h exp 1/208", ifa.fetch_req, ifa.fetch_addr); end
    endtask

    task automatic test_mid_reset();
        branch = 1'b1; btgt = 32'h300;
        step();
        branch = 1'b0;
        checks++; if ({ifa.fetch_req, ifa.fetch_addr, pc_a} !== {1'b1, 32'h208, 32'h300})
            begin errors++; $display("FAIL kill_entry got %b/%h/%h exp 1/208/300", ifa.fetch_req, ifa.fetch_addr, pc_a); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if ({ifa.fetch_req, ifa.fetch_addr, pc_a} !== {1'b0, 32'h0, 32'h0})
            begin errors++; $display("FAIL async_reset_pc got %b/%h/%h exp 0/0/0", ifa.fetch_req, ifa.fetch_addr, pc_a); end
        checks++; if ({val_a, mis_a, inst_a, ipc_a} !== 66'h0)
            begin errors++; $display("FAIL async_reset_inst got %b/%b/%h/%h exp 0", val_a, mis_a, inst_a, ipc_a); end
        rst_n = 1'b1;
        step();
        checks++; if ({ifa.fetch_req, ifa.fetch_addr} !== {1'b1, 32'h0})
            begin errors++; $display("FAIL post_reset_req got %b/%h exp 1/0", ifa.fetch_req, ifa.fetch_addr); end
    endtask

    task automatic test_wrap();
        checks++; if (pc_b !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_reset_pc got %h exp fffffffc", pc_b); end
        rstb_n = 1'b1;
        step();
        checks++; if ({ifb.fetch_req, ifb.fetch_addr} !== {1'b1, 32'hFFFF_FFFC})
            begin errors++; $display("FAIL wrap_first_req got %b/%h exp 1/fffffffc", ifb.fetch_req, ifb.fetch_addr); end
        ifb.fetch_ack = 1'b1; ifb.fetch_rdata = 32'h4444_4444;
        step();
        ifb.fetch_ack = 1'b0;
        checks++; if ({val_b, ipc_b, ifb.fetch_addr, pc_b} !== {1'b1, 32'hFFFF_FFFC, 32'h0, 32'h0})
            begin errors++; $display("FAIL wrap_addr got %b/%h/%h/%h exp 1/fffffffc/0/0", val_b, ipc_b, ifb.fetch_addr, pc_b); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_redirect_delayed_ack();
        test_trap_misaligned();
        test_stall();
        test_mid_reset();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
